muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Multi-cycle sequencer for the MULT/DIV resource and the HI/LO register pair of the multi-cycle MIPS datapath. It accepts a one-cycle start from the main control unit with operands from registers A and B. It runs a 32-iteration signed shift-add multiply or restoring divide, then writes HI/LO and pulses `done`. While it runs, the control unit holds in its wait state on `busy`.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; `ITER` = `WIDTH` iterations.

Ports:
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; all state cleared immediately.
- `start_mult`  in  1  one-cycle request: signed multiply A×B.
- `start_div`  in  1  one-cycle request: signed divide A÷B.
- `a`  in  WIDTH  operand from register A, sampled only on an accepted start.
- `b`  in  WIDTH  operand from register B, sampled only on an accepted start.
- `hi`  out  WIDTH  HI register: product upper half, or remainder.
- `lo`  out  WIDTH  LO register: product lower half, or quotient.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse when the result is committed (or the request was aborted).
- `div_zero`  out  1  one-cycle pulse, coincident with `done`, when divisor is 0.

## Operation
- States: IDLE, MULT, DIV, FINISH.
- IDLE:
  - `start_mult` → MULT.
  - `start_div` with b≠0 → DIV.
  - `start_div` with b==0 → FINISH with the div-zero flag set.
  - Both starts high: multiply wins and `start_div` is dropped.
- On accept, latch:
  - sign_a, sign_b;
  - |a|, |b| as unsigned WIDTH-bit magnitudes (|0x80000000| = 0x80000000);
  - op type;
  - iteration counter = 0.
- MULT, unsigned shift-add on magnitudes:
  - 2·WIDTH accumulator.
  - Each cycle, if multiplier LSB is set, add the multiplicand into the upper half.
  - Then shift the accumulator right 1 with carry-in.
- DIV, unsigned restoring:
  - Each cycle, shift {rem, quo} left 1, trial-subtract |b| from rem.
  - If no borrow, keep the difference and set the quotient LSB.
- After `ITER` iterations → FINISH.
- FINISH:
  - mult: negate the 64-bit product if sign_a≠sign_b.
  - div: quotient negated if sign_a≠sign_b; remainder negated if sign_a set.
  - Write hi/lo, pulse `done` → IDLE.
  - Div-zero path: hi/lo not written, `div_zero`=1.
- −2^31 ÷ −1: lo=0x80000000, hi=0 (wraps, no exception).
- Starts while not IDLE are ignored; there is no queue.

## Timing
- Reset values:
  - hi=0, lo=0, busy=0, done=0, div_zero=0;
  - state IDLE, counter 0.
  - Reset mid-operation abandons the operation and HI/LO read 0.
- Start sampled at edge k:
  - `busy` high from after edge k;
  - iterations on edges k+1..k+32;
  - hi/lo updated and `done`=1 after edge k+33.
  - `busy` low in the same cycle `done` is high.
- Div-by-zero: `done`=`div_zero`=1 after edge k+1.
- hi/lo hold their value in all states except the FINISH write; the control unit may read them in the `done` cycle.
- A new start is accepted in the cycle after `done`.
- Counter is 6 bits for `WIDTH`=32 (`$clog2(WIDTH)+1`).

## Structure
- Shared package `muldiv_pkg`:
  - state typedef (IDLE/MULT/DIV/FINISH);
  - op typedef (OP_MULT/OP_DIV);
  - `MULDIV_WIDTH`=32.
- No sub-module: FSM, counter and the shared accumulator/remainder datapath live in `muldiv_sequencer`.
- Magnitude/negate logic is a local function, reused for operands and results.

## Test plan
- Multiply 7 × −3: start at edge 0 → `done` after edge 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy high edges 1–32.
- Multiply 0x80000000 × 0x80000000 → hi=0x40000000, lo=0x00000000.
- Divide −7 ÷ 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; then 0x80000000 ÷ 0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide 5 ÷ 0 with hi/lo preloaded 0x1234/0x5678 → `done`=`div_zero`=1 one cycle after start, hi/lo unchanged, busy never asserted.
- Pulse `start_div` and `start_mult` during a running multiply, and both together from IDLE → mid-run starts ignored, result matches the original multiply; simultaneous start runs multiply.
- Assert `reset` at iteration 15 of a divide → outputs immediately 0, IDLE; next multiply 3×4 gives hi=0, lo=12 after 33 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and widths for the MULT/DIV sequencer.
package muldiv_pkg;

  localparam int unsigned MULDIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MULT   = 2'd1,
    DIV    = 2'd2,
    FINISH = 2'd3
  } state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_t;

endpackage

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed multiply / restoring divide sequencer driving HI/LO.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned W2   = 2 * WIDTH;
  localparam int unsigned ITER = WIDTH;
  localparam int unsigned CW   = $clog2(WIDTH) + 1;

  // Two's-complement negate when n is set; used for operand magnitudes and results.
  function automatic logic [W2-1:0] neg_if(input logic [W2-1:0] v, input logic n);
    return n ? (~v + W2'(1)) : v;
  endfunction

  state_t            r_state, w_state_d;
  op_t               r_op, w_op_d;
  logic [CW-1:0]     r_cnt, w_cnt_d;
  logic [W2-1:0]     r_acc, w_acc_d;
  logic [WIDTH-1:0]  r_opb, w_opb_d;
  logic              r_sign_a, w_sign_a_d;
  logic              r_sign_b, w_sign_b_d;
  logic              r_dz_flag, w_dz_flag_d;
  logic [WIDTH-1:0]  r_hi, w_hi_d;
  logic [WIDTH-1:0]  r_lo, w_lo_d;
  logic              r_busy, w_busy_d;
  logic              r_done, w_done_d;
  logic              r_div_zero, w_div_zero_d;

  logic [WIDTH:0]    w_sum;
  logic [WIDTH:0]    w_rem_sh;
  logic              w_borrow;
  logic [WIDTH-1:0]  w_diff;
  logic              w_last;

  // Iteration datapath: shift-add step for multiply, trial subtract for divide.
  always_comb begin
    w_sum    = {1'b0, r_acc[W2-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    w_rem_sh = r_acc[W2-1:WIDTH-1];
    w_borrow = (w_rem_sh < {1'b0, r_opb});
    w_diff   = WIDTH'(w_rem_sh - {1'b0, r_opb});
    w_last   = (r_cnt == CW'(ITER - 1));
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_d    = r_state;
    w_op_d       = r_op;
    w_cnt_d      = r_cnt;
    w_acc_d      = r_acc;
    w_opb_d      = r_opb;
    w_sign_a_d   = r_sign_a;
    w_sign_b_d   = r_sign_b;
    w_dz_flag_d  = r_dz_flag;
    w_hi_d       = r_hi;
    w_lo_d       = r_lo;
    w_busy_d     = 1'b0;
    w_done_d     = 1'b0;
    w_div_zero_d = 1'b0;

    case (r_state)
      IDLE: begin
        if (start_mult || start_div) begin
          w_sign_a_d  = a[WIDTH-1];
          w_sign_b_d  = b[WIDTH-1];
          w_acc_d     = {{WIDTH{1'b0}}, WIDTH'(neg_if(W2'(a), a[WIDTH-1]))};
          w_opb_d     = WIDTH'(neg_if(W2'(b), b[WIDTH-1]));
          w_cnt_d     = '0;
          w_dz_flag_d = 1'b0;
          if (start_mult) begin
            w_op_d    = OP_MULT;
            w_state_d = MULT;
            w_busy_d  = 1'b1;
          end else if (b == '0) begin
            w_op_d      = OP_DIV;
            w_dz_flag_d = 1'b1;
            w_state_d   = FINISH;
          end else begin
            w_op_d    = OP_DIV;
            w_state_d = DIV;
            w_busy_d  = 1'b1;
          end
        end
      end
      MULT: begin
        w_busy_d  = 1'b1;
        w_acc_d   = {w_sum, r_acc[WIDTH-1:1]};
        w_cnt_d   = r_cnt + CW'(1);
        if (w_last) w_state_d = FINISH;
      end
      DIV: begin
        w_busy_d  = 1'b1;
        w_acc_d   = {(w_borrow ? w_rem_sh[WIDTH-1:0] : w_diff), r_acc[WIDTH-2:0], ~w_borrow};
        w_cnt_d   = r_cnt + CW'(1);
        if (w_last) w_state_d = FINISH;
      end
      FINISH: begin
        w_state_d   = IDLE;
        w_done_d    = 1'b1;
        w_cnt_d     = '0;
        w_dz_flag_d = 1'b0;
        if (r_dz_flag) begin
          w_div_zero_d = 1'b1;
        end else if (r_op == OP_MULT) begin
          {w_hi_d, w_lo_d} = neg_if(r_acc, r_sign_a ^ r_sign_b);
        end else begin
          w_lo_d = WIDTH'(neg_if(W2'(r_acc[WIDTH-1:0]), r_sign_a ^ r_sign_b));
          w_hi_d = WIDTH'(neg_if(W2'(r_acc[W2-1:WIDTH]), r_sign_a));
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_op       <= OP_MULT;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_opb      <= '0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_dz_flag  <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_op       <= w_op_d;
      r_cnt      <= w_cnt_d;
      r_acc      <= w_acc_d;
      r_opb      <= w_opb_d;
      r_sign_a   <= w_sign_a_d;
      r_sign_b   <= w_sign_b_d;
      r_dz_flag  <= w_dz_flag_d;
      r_hi       <= w_hi_d;
      r_lo       <= w_lo_d;
      r_busy     <= w_busy_d;
      r_done     <= w_done_d;
      r_div_zero <= w_div_zero_d;
    end
  end

  assign hi       = r_hi;
  assign lo       = r_lo;
  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases plus random operations.
module tb_muldiv_sequencer;

  logic        clock;
  logic        reset;
  logic        start_mult;
  logic        start_div;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Expected contents of HI/LO as held by the bench.
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  muldiv_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .a          (a),
    .b          (b),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference: signed arithmetic on 64-bit integers, MIPS HI/LO placement.
  function automatic logic [63:0] model(input bit mul, input logic [31:0] av, input logic [31:0] bv);
    int          sa;
    int          sb;
    longint      la;
    longint      lb;
    longint      q;
    longint      r;
    logic [63:0] qv;
    logic [63:0] rv;
    sa = av;
    sb = bv;
    la = sa;
    lb = sb;
    if (mul) return la * lb;
    q  = la / lb;
    r  = la % lb;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  // One operation from IDLE; poke injects starts mid-run, both raises both starts.
  task automatic run(input bit mul, input logic [31:0] av, input logic [31:0] bv,
                     input bit poke, input bit both, input string tag);
    bit          dz;
    bit          busy_ok;
    logic [63:0] e;
    dz = !mul && !both && (bv == 32'd0);
    start_mult = mul || both;
    start_div  = !mul || both;
    a = av;
    b = bv;
    step();
    start_mult = 1'b0;
    start_div  = 1'b0;
    a = $urandom;
    b = $urandom;
    if (dz) begin
      check({tag, "_dz_busy0"}, 64'(busy), 64'd0);
      check({tag, "_dz_done0"}, 64'(done), 64'd0);
      step();
      check({tag, "_dz_done"}, {62'd0, done, div_zero}, 64'd3);
      check({tag, "_dz_busy"}, 64'(busy), 64'd0);
      check({tag, "_dz_hilo"}, {hi, lo}, {exp_hi, exp_lo});
      step();
      check({tag, "_dz_after"}, {62'd0, done, div_zero}, 64'd0);
      return;
    end
    e = model(mul || both, av, bv);
    check({tag, "_accept"}, {62'd0, busy, done}, 64'd2);
    busy_ok = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      if (poke) begin
        if (i == 4)  begin start_div  = 1'b1; a = 32'h0000_0009; b = 32'd0; end
        if (i == 5)  start_div  = 1'b0;
        if (i == 9)  begin start_mult = 1'b1; a = 32'h1234_5678; b = 32'h0000_0003; end
        if (i == 10) start_mult = 1'b0;
      end
      step();
      if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
    end
    check({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
    step();
    check({tag, "_done"}, {61'd0, done, busy, div_zero}, 64'd4);
    check({tag, "_hilo"}, {hi, lo}, e);
    exp_hi = e[63:32];
    exp_lo = e[31:0];
    step();
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_hold"}, {hi, lo}, {exp_hi, exp_lo});
  endtask

  initial begin
    logic [31:0] av;
    logic [31:0] bv;
    bit          mul;

    reset      = 1'b1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    a          = '0;
    b          = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_outputs", {hi, lo}, 64'd0);
    check("reset_flags", {61'd0, busy, done, div_zero}, 64'd0);
    reset = 1'b0;
    step();
    check("post_reset_idle", {61'd0, busy, done, div_zero}, 64'd0);

    run(1'b1, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0, "mul_7_m3");
    check("mul_7_m3_const", {exp_hi, exp_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, "mul_min_min");
    check("mul_min_min_const", {exp_hi, exp_lo}, 64'h4000_0000_0000_0000);
    run(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "div_m7_2");
    check("div_m7_2_const", {exp_hi, exp_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "div_min_m1");
    check("div_min_m1_const", {exp_hi, exp_lo}, 64'h0000_0000_8000_0000);
    run(1'b0, 32'h5678_1234, 32'h0001_0000, 1'b0, 1'b0, "preload");
    check("preload_const", {exp_hi, exp_lo}, 64'h0000_1234_0000_5678);
    run(1'b0, 32'd5, 32'd0, 1'b0, 1'b0, "div_5_0");
    run(1'b1, 32'hFFFF_FF00, 32'h0000_0123, 1'b1, 1'b0, "mul_poked");
    run(1'b0, 32'h0000_0064, 32'h0000_0007, 1'b0, 1'b1, "both_starts");

    // Reset in the middle of a divide.
    start_div = 1'b1;
    a = 32'h0000_0064;
    b = 32'h0000_0007;
    step();
    start_div = 1'b0;
    repeat (15) step();
    reset = 1'b1;
    #1;
    check("midreset_hilo", {hi, lo}, 64'd0);
    check("midreset_flags", {61'd0, busy, done, div_zero}, 64'd0);
    #1;
    reset = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    step();
    check("midreset_idle", {61'd0, busy, done, div_zero}, 64'd0);
    run(1'b1, 32'd3, 32'd4, 1'b0, 1'b0, "mul_3_4");
    check("mul_3_4_const", {exp_hi, exp_lo}, 64'd12);

    // Random mix of multiplies and divides, including corner operands.
    for (int i = 0; i < 24; i++) begin
      mul = ($urandom_range(0, 1) == 1);
      av  = $urandom;
      bv  = $urandom;
      case ($urandom_range(0, 7))
        0: bv = 32'd0;
        1: av = 32'h8000_0000;
        2: bv = 32'h0000_0000 + $urandom_range(1, 16);
        3: bv = 32'hFFFF_FFFF - $urandom_range(0, 15);
        default: ;
      endcase
      run(mul, av, bv, (i % 5) == 0, 1'b0, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
